keystream_byte_cipher: RTL and testbench
========================================

Name: keystream_byte_cipher

Overview:
Downstream consumer of the 128-bit LFSR PRNG's serial keystream. It samples the keystream bit in the PRNG's slow divided-clock domain and packs successive bits into bytes in a 2-entry buffer. Each buffered byte is XORed with one input data byte under a valid/ready handshake. The block is the encrypt/decrypt datapath that sits between the PRNG and the byte-stream transport.

Parameters:
DATA_W, 8, keystream/data word width in bits; must be ≥2.
KS_DEPTH, 2, keystream word buffer entries; fixed at 2 in this revision.

Ports:
i_clk  in  1  system clock; all logic is in this domain.
i_rst  in  1  asynchronous reset, active-low.
i_clr  in  1  synchronous clear of packer, buffer and overrun flag; used on reseed.
i_ks_clk  in  1  PRNG divided clock, sampled as data. Divide ratio ≥4 i_clk periods per half-cycle.
i_ks_bit  in  1  PRNG serial keystream bit, stable around i_ks_clk falling edge.
i_data  in  DATA_W  plaintext/ciphertext input word.
i_valid  in  1  i_data valid.
o_ready  out  1  block accepts i_data this cycle.
o_data  out  DATA_W  i_data XOR keystream word.
o_valid  out  1  o_data valid.
i_ready  in  1  downstream accepts o_data.
o_ks_level  out  2  buffered keystream words (0..2).
o_overrun  out  1  sticky: a keystream word was discarded.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_ready=0, o_ks_level=0, o_overrun=0. Packer bit count, shift register and sync flops are all 0.
- Sync: i_ks_clk and i_ks_bit pass through the same 2-flop synchroniser. A third flop on the clock path gives the edge detect.
- Sample strobe: asserted for one cycle when the synced clock goes 1→0. The synced bit is captured on that strobe.
- Packer: shifts MSB-first (first sampled bit ends in bit DATA_W-1). A counter runs 0..DATA_W-1.
- Word push: when the DATA_W-th bit is captured, the word is pushed into the buffer the same cycle and the counter wraps to 0.
- Buffer states: EMPTY → ONE → FULL; push increments, pop decrements. o_ks_level is the state encoding (0/1/2). Read is FIFO order.
- Push while FULL without a simultaneous pop: word discarded, o_overrun set and held until i_clr or reset. Existing entries are untouched.
- Push and pop in the same cycle: pop is applied first, so a FULL buffer stays FULL and no overrun occurs. In EMPTY a same-cycle push cannot be popped; the word lands first and can be popped from the next cycle.
- o_ready = (level≠0) AND (!o_valid OR i_ready). It is combinational from registered state and i_ready only, never from i_valid.
- Accept: i_valid AND o_ready. On accept, o_data <= i_data XOR head word, the buffer pops and o_valid <= 1. Latency is one cycle.
- Output hold: o_valid AND !i_ready holds o_data and o_valid stable.
- Output release: o_valid AND i_ready with no accept clears o_valid the next cycle.
- Back-to-back: full throughput of one word per cycle while the buffer has data.
- i_clr: same-cycle effect on packer count, buffer (level 0), o_overrun and o_valid. o_data keeps its value. The sync flops are not cleared.
- Reset mid-byte or mid-transfer: everything returns to reset values and partial bits are lost. The first strobe after release is bit DATA_W-1 of a fresh word.

Optional Feature:
KS_BYTE_CNT_EN
- Defined: adds output o_word_cnt[31:0], incremented on each accepted transfer. It wraps 0xFFFFFFFF→0 and is cleared by reset and i_clr.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package prng_cipher_pkg:
  - DATA_W default constant.
  - KS_DEPTH constant.
  - Buffer state enum {KS_EMPTY, KS_ONE, KS_FULL}.
- Sub-module ks_bit_sync: 2-flop synchroniser plus falling-edge detector. Outputs the sample strobe and synced bit.
- Packer, buffer and cipher stage stay in the top module.

Test Plan:
- Bits 1,0,1,1,0,0,1,0 (divide ratio 8), then i_data=0xFF with i_valid and i_ready high → o_ready rises after the 8th strobe; the cycle after accept, o_data=0x4D and o_valid=1.
- Three words 0xB2, 0x0F, 0xAA fed with i_valid=0 → o_ks_level=2 and o_overrun=1 after the third. Two transfers of 0x00 then give 0xB2, 0x0F, and o_ks_level returns to 0.
- Level 2, i_ready=0, accept one word → o_valid held, o_data stable, o_ready=0 over 5 cycles. Raising i_ready gives exactly one transfer.
- Level 2 with a pop on the same cycle as the next word push → level stays 2 and o_overrun stays 0.
- Drive 5 bits, pulse i_rst low for 2 cycles, then 8 bits 0xC3 → buffered word 0xC3; i_data=0x3C gives o_data=0xFF.
- KS_BYTE_CNT_EN defined: 4 transfers → o_word_cnt=4, then i_clr → 0. Preload 0xFFFFFFFF, one transfer → 0.

Source files
------------

// File: rtl/keystream_byte_cipher_pkg.sv
// Shared constants and buffer-state encoding for the keystream byte cipher.
// The optional accepted-word counter is enabled by KS_BYTE_CNT_EN.
package prng_cipher_pkg;

   localparam int DATA_W_DEFAULT = 8;
   localparam int KS_DEPTH       = 2;

   typedef enum logic [1:0] {
      KS_EMPTY = 2'd0,
      KS_ONE   = 2'd1,
      KS_FULL  = 2'd2
   } ks_state_e;

endpackage

// File: rtl/keystream_byte_cipher_if.sv
// Valid/ready byte-stream bundle: input words in, ciphered words out.
// slave = cipher side, master = producer/consumer side.
interface keystream_byte_cipher_if #(
   parameter int DATA_W = prng_cipher_pkg::DATA_W_DEFAULT
);
   logic [DATA_W-1:0] i_data;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_ready;

   modport slave (
      input  i_data, i_valid, i_ready,
      output o_ready, o_data, o_valid
   );

   modport master (
      output i_data, i_valid, i_ready,
      input  o_ready, o_data, o_valid
   );
endinterface

// File: rtl/keystream_byte_cipher_sync.sv
// Two-flop synchroniser for the PRNG clock/bit plus falling-edge strobe.
// The strobe marks the cycle in which the synced bit is to be sampled.
module ks_bit_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ks_clk,
   input  logic i_ks_bit,
   output logic o_strobe,
   output logic o_bit
);
   logic [2:0] clk_sync_q, clk_sync_d;
   logic [1:0] bit_sync_q, bit_sync_d;

   always_comb begin
      clk_sync_d = {clk_sync_q[1:0], i_ks_clk};
      bit_sync_d = {bit_sync_q[0], i_ks_bit};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         clk_sync_q <= '0;
         bit_sync_q <= '0;
      end else begin
         clk_sync_q <= clk_sync_d;
         bit_sync_q <= bit_sync_d;
      end
   end

   assign o_strobe = clk_sync_q[2] & ~clk_sync_q[1];
   assign o_bit    = bit_sync_q[1];
endmodule

// File: rtl/keystream_byte_cipher.sv
// Packs PRNG keystream bits into a 2-word buffer and XORs them onto a byte stream.
// Define KS_BYTE_CNT_EN to add the o_word_cnt accepted-transfer counter.
module keystream_byte_cipher
   import prng_cipher_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_ks_clk,
   input  logic       i_ks_bit,
   keystream_byte_cipher_if.slave bus,
   output logic [1:0] o_ks_level,
   output logic       o_overrun
`ifdef KS_BYTE_CNT_EN
   ,
   output logic [31:0] o_word_cnt
`endif
);
   localparam int CW = $clog2(DATA_W);

   logic              ks_strobe;
   logic              ks_bit;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              ks_push;
   logic [DATA_W-1:0] ks_word;
   ks_state_e         state_q, state_d;
   logic [DATA_W-1:0] buf_q [KS_DEPTH];
   logic [DATA_W-1:0] buf_d [KS_DEPTH];
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic              ovalid_q, ovalid_d;
   logic              accept;

   ks_bit_sync u_sync (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_ks_clk (i_ks_clk),
      .i_ks_bit (i_ks_bit),
      .o_strobe (ks_strobe),
      .o_bit    (ks_bit)
   );

   always_comb begin
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      ks_push = 1'b0;
      ks_word = {sh_q[DATA_W-2:0], ks_bit};
      if (ks_strobe) begin
         sh_d = ks_word;
         if (cnt_q == CW'(DATA_W - 1)) begin
            ks_push = 1'b1;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (i_clr) begin
         cnt_d   = '0;
         sh_d    = '0;
         ks_push = 1'b0;
      end
   end

   // Ready never looks at i_valid, so upstream may wait on it freely.
   assign bus.o_ready = (state_q != KS_EMPTY) && (!ovalid_q || bus.i_ready);
   assign accept      = bus.i_valid && bus.o_ready;

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      overrun_d = overrun_q;
      unique case (state_q)
         KS_EMPTY: begin
            if (ks_push) begin
               buf_d[0] = ks_word;
               state_d  = KS_ONE;
            end
         end
         KS_ONE: begin
            unique case ({accept, ks_push})
               2'b11: buf_d[0] = ks_word;
               2'b10: state_d = KS_EMPTY;
               2'b01: begin
                  buf_d[1] = ks_word;
                  state_d  = KS_FULL;
               end
               default: ;
            endcase
         end
         KS_FULL: begin
            if (accept) begin
               buf_d[0] = buf_q[1];
               if (ks_push) buf_d[1] = ks_word;
               else         state_d  = KS_ONE;
            end else if (ks_push) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = KS_EMPTY;
      endcase
      if (i_clr) begin
         state_d   = KS_EMPTY;
         overrun_d = 1'b0;
      end
   end

   always_comb begin
      odata_d  = odata_q;
      ovalid_d = ovalid_q;
      if (accept) begin
         odata_d  = bus.i_data ^ buf_q[0];
         ovalid_d = 1'b1;
      end else if (ovalid_q && bus.i_ready) begin
         ovalid_d = 1'b0;
      end
      if (i_clr) begin
         odata_d  = odata_q;
         ovalid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q     <= '0;
         sh_q      <= '0;
         state_q   <= KS_EMPTY;
         buf_q     <= '{default: '0};
         overrun_q <= 1'b0;
         odata_q   <= '0;
         ovalid_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         state_q   <= state_d;
         buf_q     <= buf_d;
         overrun_q <= overrun_d;
         odata_q   <= odata_d;
         ovalid_q  <= ovalid_d;
      end
   end

   assign bus.o_data  = odata_q;
   assign bus.o_valid = ovalid_q;
   assign o_ks_level  = state_q;
   assign o_overrun   = overrun_q;

`ifdef KS_BYTE_CNT_EN
   logic [31:0] word_cnt_q, word_cnt_d;

   always_comb begin
      word_cnt_d = word_cnt_q;
      if (accept) word_cnt_d = word_cnt_q + 32'd1;
      if (i_clr)  word_cnt_d = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) word_cnt_q <= '0;
      else        word_cnt_q <= word_cnt_d;
   end

   assign o_word_cnt = word_cnt_q;
`endif
endmodule

// File: tb/tb_keystream_byte_cipher.sv
// Bench for keystream_byte_cipher: vector table, corner sequences, random run.
// Counter checks are compiled in when KS_BYTE_CNT_EN is defined.
module tb_keystream_byte_cipher;
   import prng_cipher_pkg::*;

   typedef struct {
      logic [7:0] ks;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       ks_clk = 1'b0;
   logic       ks_bit = 1'b0;
   logic [1:0] level;
   logic       overrun;
`ifdef KS_BYTE_CNT_EN
   logic [31:0] word_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] ks_model[$];
   logic [7:0] exp_q[$];
   bit         prod_done;
   bit         rnd_run;
   int         nxfer;

   vec_t tbl[6];

   keystream_byte_cipher_if #(.DATA_W(8)) bus ();

   keystream_byte_cipher dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .i_clr      (clr),
      .i_ks_clk   (ks_clk),
      .i_ks_bit   (ks_bit),
      .bus        (bus),
      .o_ks_level (level),
      .o_overrun  (overrun)
`ifdef KS_BYTE_CNT_EN
      ,
      .o_word_cnt (word_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ks_send_bit(logic b, int r);
      ks_bit = b;
      ks_clk = 1'b1;
      cyc(r);
      ks_clk = 1'b0;
      cyc(r);
   endtask

   task automatic ks_send_byte(logic [7:0] w, int r);
      for (int i = 7; i >= 0; i--) ks_send_bit(w[i], r);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
   endtask

   task automatic xfer(logic [7:0] d, logic [7:0] exp, string name);
      bus.i_data  = d;
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      cyc(1);
      bus.i_valid = 1'b0;
      chk({name, "_valid"}, bus.o_valid, 1'b1);
      chk(name, bus.o_data, exp);
   endtask

   task automatic rnd_producer(int nw);
      logic [7:0] w;
      for (int i = 0; i < nw; i++) begin
         w = 8'($urandom);
         ks_model.push_back(w);
         ks_send_byte(w, $urandom_range(4, 6));
      end
      prod_done = 1'b1;
   endtask

   task automatic rnd_driver();
      int c;
      for (c = 0; c < 20000; c++) begin
         if (prod_done && ks_model.size() == 0 && exp_q.size() == 0)
            break;
         bus.i_valid = 1'($urandom);
         bus.i_data  = 8'($urandom);
         bus.i_ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      if (c >= 20000) begin
         n_cmp++;
         n_err++;
         $display("FAIL rnd_timeout: got %0d cycles limit 20000", c);
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      cyc(2);
      rnd_run = 1'b0;
   endtask

   task automatic rnd_monitor();
      bit         hold_pend = 1'b0;
      logic [7:0] hold_data = '0;
      while (rnd_run) begin
         @(negedge clk);
         if (!rnd_run) break;
         if (hold_pend) begin
            chk("rnd_hold_valid", bus.o_valid, 1'b1);
            chk("rnd_hold_data", bus.o_data, hold_data);
         end
         hold_pend = bus.o_valid && !bus.i_ready;
         hold_data = bus.o_data;
         if (ks_model.size() == 0)
            chk("rnd_ready_empty", bus.o_ready, 1'b0);
         if (bus.o_valid && bus.i_ready) begin
            nxfer++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rnd_extra_out: got 0x%0h expected none",
                        bus.o_data);
            end else begin
               chk("rnd_data", bus.o_data, exp_q.pop_front());
            end
         end
         if (bus.i_valid && bus.o_ready) begin
            if (ks_model.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL rnd_accept_no_ks: got accept expected none");
            end else begin
               exp_q.push_back(bus.i_data ^ ks_model.pop_front());
            end
         end
      end
   endtask

   initial begin
      int   n;
      bit   seen;
      logic [7:0] held;

      tbl[0] = '{ks: 8'hB2, din: 8'hFF, exp: 8'h4D};
      tbl[1] = '{ks: 8'hC3, din: 8'h3C, exp: 8'hFF};
      tbl[2] = '{ks: 8'h00, din: 8'h5A, exp: 8'h5A};
      tbl[3] = '{ks: 8'hFF, din: 8'h0F, exp: 8'hF0};
      tbl[4] = '{ks: 8'h81, din: 8'h81, exp: 8'h00};
      tbl[5] = '{ks: 8'h6E, din: 8'h00, exp: 8'h6E};

      bus.i_data  = '0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;

      cyc(3);
      chk("rst_odata", bus.o_data, 8'h00);
      chk("rst_ovalid", bus.o_valid, 1'b0);
      chk("rst_oready", bus.o_ready, 1'b0);
      chk("rst_level", level, 2'd0);
      chk("rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      cyc(2);

      // Table: 7 bits give nothing, the 8th makes a word ready.
      for (int v = 0; v < 6; v++) begin
         for (int i = 7; i >= 1; i--) ks_send_bit(tbl[v].ks[i], 8);
         chk("tbl_ready_pre", bus.o_ready, 1'b0);
         ks_send_bit(tbl[v].ks[0], 8);
         chk("tbl_level", level, 2'd1);
         chk("tbl_ready", bus.o_ready, 1'b1);
         xfer(tbl[v].din, tbl[v].exp, "tbl_data");
         chk("tbl_level_after", level, 2'd0);
      end

      // Overrun on the third word.
      do_clr();
      ks_send_byte(8'hB2, 8);
      ks_send_byte(8'h0F, 8);
      chk("ovr_level2", level, 2'd2);
      chk("ovr_none_yet", overrun, 1'b0);
      ks_send_byte(8'hAA, 8);
      chk("ovr_level", level, 2'd2);
      chk("ovr_flag", overrun, 1'b1);
      xfer(8'h00, 8'hB2, "ovr_w0");
      xfer(8'h00, 8'h0F, "ovr_w1");
      cyc(1);
      chk("ovr_level0", level, 2'd0);
      chk("ovr_sticky", overrun, 1'b1);
      do_clr();
      chk("ovr_clr", overrun, 1'b0);

      // Output hold under backpressure.
      ks_send_byte(8'h11, 8);
      ks_send_byte(8'h22, 8);
      bus.i_ready = 1'b0;
      bus.i_data  = 8'h00;
      bus.i_valid = 1'b1;
      cyc(1);
      bus.i_valid = 1'b0;
      held = 8'h11;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_valid", bus.o_valid, 1'b1);
         chk("hold_data", bus.o_data, held);
         chk("hold_ready", bus.o_ready, 1'b0);
      end
      cyc(0);
      @(posedge clk);
      #1 bus.i_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.o_valid && bus.i_ready) n++;
      end
      chk("hold_one_xfer", n, 1);
      chk("hold_level", level, 2'd1);
      cyc(1);
      do_clr();

      // Pop and push land in the same cycle at level 2.
      ks_send_byte(8'h5A, 8);
      ks_send_byte(8'hA5, 8);
      for (int i = 7; i >= 1; i--) ks_send_bit(1'(8'h3C >> i), 8);
      ks_bit = 1'b0;
      ks_clk = 1'b1;
      cyc(8);
      ks_clk = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dut.ks_push) begin
            seen = 1'b1;
            break;
         end
      end
      chk("same_push_seen", seen, 1'b1);
      bus.i_data  = 8'h00;
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b1;
      @(posedge clk);
      #1 bus.i_valid = 1'b0;
      chk("same_level", level, 2'd2);
      chk("same_overrun", overrun, 1'b0);
      chk("same_data", bus.o_data, 8'h5A);
      xfer(8'h00, 8'hA5, "same_w1");
      xfer(8'h00, 8'h3C, "same_w2");
      cyc(2);
      do_clr();

      // Reset in the middle of a word.
      for (int i = 0; i < 5; i++) ks_send_bit(1'b1, 8);
      rst_n = 1'b0;
      cyc(2);
      chk("mid_rst_level", level, 2'd0);
      chk("mid_rst_valid", bus.o_valid, 1'b0);
      rst_n = 1'b1;
      cyc(1);
      ks_send_byte(8'hC3, 8);
      chk("mid_level", level, 2'd1);
      xfer(8'h3C, 8'hFF, "mid_data");
      cyc(2);

`ifdef KS_BYTE_CNT_EN
      do_clr();
      for (int i = 0; i < 4; i++) begin
         ks_send_byte(8'(i * 37), 5);
         xfer(8'h00, 8'(i * 37), "cnt_data");
      end
      cyc(1);
      chk("cnt_four", word_cnt, 32'd4);
      do_clr();
      chk("cnt_clr", word_cnt, 32'd0);
`endif

      // Random traffic against the queue model.
      do_clr();
      ks_model.delete();
      exp_q.delete();
      prod_done = 1'b0;
      rnd_run   = 1'b1;
      nxfer     = 0;
      fork
         rnd_producer(10);
         rnd_driver();
         rnd_monitor();
      join
      chk("rnd_xfers", nxfer, 10);
      chk("rnd_overrun", overrun, 1'b0);
      chk("rnd_level", level, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
